cache_mem_pair: RTL and testbench

- Storage back-end of the 1 MB direct-mapped cache: a 2^18 x 32 data block RAM plus a 2^14 x 13 tag table ({valid, tag[11:0]}) in distributed RAM.
- The cache controller drives both arrays each cycle.
- After reset the block invalidates the whole tag table itself, so every lookup misses until a line is filled.

---
 rtl/cache_pkg.sv | 16 +
 rtl/cache_bram_sp.sv | 25 ++
 rtl/cache_distram_sp.sv | 20 ++
 rtl/cache_mem_pair.sv | 78 +++++++
 tb/tb_cache_mem_pair.sv | 136 +++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared widths and types for the cache storage back-end.
package cache_pkg;
  localparam int DATA_AW  = 18;
  localparam int DATA_W   = 32;
  localparam int TAG_AW   = 14;
  localparam int TAG_W    = 13;
  localparam int GTAG_W   = 12;
  localparam int OFFSET_W = 4;

  typedef struct packed {
    logic              valid;
    logic [GTAG_W-1:0] gtag;
  } tag_entry_t;

  typedef enum logic {INIT, RUN} init_state_t;
endpackage

// File: rtl/cache_bram_sp.sv
// Single-port read-first data array; read data registered, 1-cycle latency.
// No backpressure: one access per cycle, always accepted.
module cache_bram_sp #(
  parameter int AW = 18,
  parameter int W  = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  din,
  input  logic          we,
  output logic [W-1:0]  dout
);
  logic [W-1:0] mem [0:(1<<AW)-1];

  // Array kept reset-free so it maps onto block RAM; only the output register resets.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dout <= '0;
    else        dout <= mem[addr];
  end
endmodule

// File: rtl/cache_distram_sp.sv
// Single-port LUT-RAM tag array: synchronous write, combinational read.
// No backpressure: one access per cycle, always accepted.
module cache_distram_sp #(
  parameter int AW = 14,
  parameter int W  = 13
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  din,
  input  logic          we,
  output logic [W-1:0]  dout
);
  logic [W-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
  end

  assign dout = mem[addr];
endmodule

// File: rtl/cache_mem_pair.sv
// Cache data RAM + tag table with post-reset tag invalidation sweep (2^TAG_AW cycles).
// Latency: data read 1 cycle, tag read combinational; tag writes dropped while init_busy.
module cache_mem_pair
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DATA_AW-1:0] data_addr,
  input  logic [DATA_W-1:0]  data_din,
  input  logic               data_we,
  output logic [DATA_W-1:0]  data_dout,
  input  logic [TAG_AW-1:0]  tag_addr,
  input  logic [TAG_W-1:0]   tag_din,
  input  logic               tag_we,
  output logic [TAG_W-1:0]   tag_dout,
  output logic               init_busy
);
  localparam logic [TAG_AW-1:0] CNT_LAST = '1;

  init_state_t        state, state_nxt;
  logic [TAG_AW-1:0]  cnt, cnt_nxt;
  logic [TAG_AW-1:0]  tag_ram_addr;
  tag_entry_t         tag_ram_din;
  tag_entry_t         tag_ram_dout;
  logic               tag_ram_we;

  cache_bram_sp #(.AW(DATA_AW), .W(DATA_W)) u_data (
    .clk  (clk),
    .rst_n(rst_n),
    .addr (data_addr),
    .din  (data_din),
    .we   (data_we),
    .dout (data_dout)
  );

  cache_distram_sp #(.AW(TAG_AW), .W(TAG_W)) u_tag (
    .clk (clk),
    .addr(tag_ram_addr),
    .din (tag_ram_din),
    .we  (tag_ram_we),
    .dout(tag_ram_dout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Sweep owns the tag port until the last entry is cleared; the counter's
  // terminal value moves to RUN, which is absorbing, so a wrap never re-enters INIT.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    tag_ram_addr = tag_addr;
    tag_ram_din  = tag_entry_t'(tag_din);
    tag_ram_we   = tag_we;
    tag_dout     = tag_ram_dout;
    unique case (state)
      INIT: begin
        tag_ram_addr = cnt;
        tag_ram_din  = '0;
        tag_ram_we   = 1'b1;
        tag_dout     = '0;
        cnt_nxt      = cnt + 1'b1;
        if (cnt == CNT_LAST) state_nxt = RUN;
      end
      RUN: ;
      default: state_nxt = INIT;
    endcase
  end

  assign init_busy = (state == INIT);
endmodule

// File: tb/tb_cache_mem_pair.sv
// Directed bench for cache_mem_pair: init sweep timing, tag/data access, mid-sweep reset.
module tb_cache_mem_pair;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [17:0] data_addr;
  logic [31:0] data_din;
  logic        data_we;
  logic [31:0] data_dout;
  logic [13:0] tag_addr;
  logic [12:0] tag_din;
  logic        tag_we;
  logic [12:0] tag_dout;
  logic        init_busy;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  cache_mem_pair dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_addr(data_addr),
    .data_din (data_din),
    .data_we  (data_we),
    .data_dout(data_dout),
    .tag_addr (tag_addr),
    .tag_din  (tag_din),
    .tag_we   (tag_we),
    .tag_dout (tag_dout),
    .init_busy(init_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Counts edges after reset release until init_busy drops; optionally
  // probes tag_dout mid-sweep. Bounded so a stuck sweep cannot hang the run.
  task automatic wait_init(input string tag);
    int n;
    bit done;
    n = 0;
    done = 0;
    while (!done && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 100) check({tag, "_tag_forced0"}, 32'(tag_dout), 32'h0);
      if (!init_busy) done = 1;
    end
    tag_we = 1'b0;
    check({tag, "_busy_cycles"}, 32'(n), 32'd16384);
  endtask

  task automatic tag_read(input string tag, input logic [13:0] a, input logic [12:0] exp);
    tag_addr = a;
    #1;
    check(tag, 32'(tag_dout), 32'(exp));
  endtask

  initial begin
    rst_n = 1'b0;
    data_addr = '0; data_din = '0; data_we = 1'b0;
    // tag write held active through the whole sweep: must be dropped
    tag_addr = 14'h0003; tag_din = 13'h1FFF; tag_we = 1'b1;
    #12;
    check("rst_dout", data_dout, 32'h0);
    check("rst_busy", 32'(init_busy), 32'h1);
    @(negedge clk) rst_n = 1'b1;
    wait_init("init1");

    tag_read("tag_0",     14'd0,     13'h0);
    tag_read("tag_8191",  14'd8191,  13'h0);
    tag_read("tag_16383", 14'd16383, 13'h0);
    tag_read("tag_3_dropped", 14'd3, 13'h0);

    @(negedge clk);
    tag_addr = 14'h0005; tag_din = 13'h1ABC; tag_we = 1'b1;
    @(posedge clk); #1;
    tag_we = 1'b0;
    check("tag_wr5", 32'(tag_dout), 32'h1ABC);
    tag_read("tag_6", 14'h0006, 13'h0);

    @(negedge clk);
    data_addr = 18'h3FFFF; data_din = 32'hDEADBEEF; data_we = 1'b1;
    @(negedge clk) data_we = 1'b0;
    @(posedge clk); #1;
    check("data_rd", data_dout, 32'hDEADBEEF);

    @(negedge clk);
    data_din = 32'h12345678; data_we = 1'b1;
    @(posedge clk); #1;
    check("data_read_first", data_dout, 32'hDEADBEEF);
    @(negedge clk) data_we = 1'b0;
    @(posedge clk); #1;
    check("data_new", data_dout, 32'h12345678);

    @(negedge clk);
    data_addr = 18'h00010; data_din = 32'hCAFEF00D; data_we = 1'b1;
    @(negedge clk);
    data_we = 1'b0; data_addr = 18'h3FFFF;
    @(posedge clk); #1;
    check("data_other_addr", data_dout, 32'h12345678);
    @(negedge clk) data_addr = 18'h00010;
    @(posedge clk); #1;
    check("data_addr10", data_dout, 32'hCAFEF00D);

    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (5000) @(posedge clk);
    #1;
    check("sweep5000_busy", 32'(init_busy), 32'h1);
    check("sweep_data_live", data_dout, 32'hCAFEF00D);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_dout", data_dout, 32'h0);
    check("async_rst_busy", 32'(init_busy), 32'h1);
    @(negedge clk) rst_n = 1'b1;
    wait_init("init2");

    tag_read("tag5_cleared", 14'h0005, 13'h0);
    @(negedge clk);
    tag_addr = 14'h0007; tag_din = 13'h0ABC; tag_we = 1'b1;
    @(posedge clk); #1;
    tag_we = 1'b0;
    check("tag_wr7", 32'(tag_dout), 32'h0ABC);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
